// File: rtl/mac_pkg.sv
// Shared constants and state encoding for the mac_sched classifier controller.
package mac_pkg;
   localparam int DATA_W = 128;
   localparam int SUM_W  = 20;
   localparam int CLS_W  = 4;
   localparam int IMG_AW = 6;
   localparam int LANES  = 16;

   // 16 lanes x 255 x 255: the largest value mac1 can ever produce
   localparam logic [SUM_W-1:0] MAX_SUM = 20'hFE010;

   typedef enum logic [2:0] {
      IDLE,
      RD_IMG,
      RD_W,
      LOAD,
      CMP,
      OUT
   } state_t;
endpackage

// File: rtl/mac_sched_if.sv
// Bus between mac_sched and its environment: control, both ROMs, mac1 and the result sink.
interface mac_sched_if;
   import mac_pkg::*;

   logic              start;
   logic              busy;
   logic              done;
   logic [IMG_AW-1:0] img_addr;
   logic              img_re;
   logic [DATA_W-1:0] img_rdata;
   logic [CLS_W-1:0]  w_addr;
   logic              w_re;
   logic [DATA_W-1:0] w_rdata;
   logic [DATA_W-1:0] mac_p;
   logic [DATA_W-1:0] mac_w;
   logic [SUM_W-1:0]  mac_s;
   logic              result_valid;
   logic              result_ready;
   logic [IMG_AW-1:0] result_idx;
   logic [CLS_W-1:0]  result_class;
   logic [SUM_W-1:0]  result_score;

   modport master (
      input  start, img_rdata, w_rdata, mac_s, result_ready,
      output busy, done, img_addr, img_re, w_addr, w_re, mac_p, mac_w,
             result_valid, result_idx, result_class, result_score
   );

   modport slave (
      output start, img_rdata, w_rdata, mac_s, result_ready,
      input  busy, done, img_addr, img_re, w_addr, w_re, mac_p, mac_w,
             result_valid, result_idx, result_class, result_score
   );
endinterface

// File: rtl/mac_argmax.sv
// Running arg-max over one image's class sums; ties keep the earlier (lower) class.
module mac_argmax
   import mac_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             en_i,
   input  logic             first_i,
   input  logic [SUM_W-1:0] score_i,
   input  logic [CLS_W-1:0] cls_i,
   output logic [SUM_W-1:0] best_score_o,
   output logic [CLS_W-1:0] best_cls_o
);
   logic [SUM_W-1:0] best_score_q;
   logic [CLS_W-1:0] best_cls_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         best_score_q <= '0;
         best_cls_q   <= '0;
      end else if (en_i && (first_i || (score_i > best_score_q))) begin
         best_score_q <= score_i;
         best_cls_q   <= cls_i;
      end
   end

   assign best_score_o = best_score_q;
   assign best_cls_o   = best_cls_q;
endmodule

// File: rtl/mac_sched.sv
// Sequences mac1 over every (image, class) pair of a batch and emits one arg-max result per image.
module mac_sched
   import mac_pkg::*;
#(
   parameter int NUM_IMAGES  = 40,
   parameter int NUM_CLASSES = 10
) (
   input logic         clk,
   input logic         rst,
   mac_sched_if.master bus
);
   localparam logic [IMG_AW-1:0] LAST_IMG = IMG_AW'(NUM_IMAGES - 1);
   localparam logic [CLS_W-1:0]  LAST_CLS = CLS_W'(NUM_CLASSES - 1);

   state_t            state_q, state_d;
   logic [IMG_AW-1:0] img_idx_q, img_idx_d;
   logic [CLS_W-1:0]  cls_q, cls_d;
   logic [DATA_W-1:0] p_hold_q, p_hold_d;
   logic [DATA_W-1:0] mac_p_q, mac_p_d;
   logic [DATA_W-1:0] mac_w_q, mac_w_d;
   logic              done_q, done_d;
   logic              img_re, w_re, res_valid, am_en;
   logic [SUM_W-1:0]  best_score;
   logic [CLS_W-1:0]  best_cls;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         img_idx_q <= '0;
         cls_q     <= '0;
         p_hold_q  <= '0;
         mac_p_q   <= '0;
         mac_w_q   <= '0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         img_idx_q <= img_idx_d;
         cls_q     <= cls_d;
         p_hold_q  <= p_hold_d;
         mac_p_q   <= mac_p_d;
         mac_w_q   <= mac_w_d;
         done_q    <= done_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      img_idx_d = img_idx_q;
      cls_d     = cls_q;
      p_hold_d  = p_hold_q;
      mac_p_d   = mac_p_q;
      mac_w_d   = mac_w_q;
      done_d    = 1'b0;
      img_re    = 1'b0;
      w_re      = 1'b0;
      res_valid = 1'b0;
      am_en     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               img_idx_d = '0;
               state_d   = RD_IMG;
            end
         end
         RD_IMG: begin
            img_re  = 1'b1;
            cls_d   = '0;
            state_d = RD_W;
         end
         RD_W: begin
            // The image word arrives only once per image; hold it across all classes
            w_re = 1'b1;
            if (cls_q == '0) p_hold_d = bus.img_rdata;
            state_d = LOAD;
         end
         LOAD: begin
            mac_p_d = p_hold_q;
            mac_w_d = bus.w_rdata;
            state_d = CMP;
         end
         CMP: begin
            am_en = 1'b1;
            if (cls_q == LAST_CLS) begin
               state_d = OUT;
            end else begin
               cls_d   = cls_q + CLS_W'(1);
               state_d = RD_W;
            end
         end
         OUT: begin
            res_valid = 1'b1;
            if (bus.result_ready) begin
               if (img_idx_q == LAST_IMG) begin
                  done_d  = 1'b1;
                  state_d = IDLE;
               end else begin
                  img_idx_d = img_idx_q + IMG_AW'(1);
                  state_d   = RD_IMG;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   mac_argmax u_argmax (
      .clk          (clk),
      .rst          (rst),
      .en_i         (am_en),
      .first_i      (cls_q == '0),
      .score_i      (bus.mac_s),
      .cls_i        (cls_q),
      .best_score_o (best_score),
      .best_cls_o   (best_cls)
   );

   assign bus.busy         = (state_q != IDLE);
   assign bus.done         = done_q;
   assign bus.img_addr     = img_idx_q;
   assign bus.img_re       = img_re;
   assign bus.w_addr       = cls_q;
   assign bus.w_re         = w_re;
   assign bus.mac_p        = mac_p_q;
   assign bus.mac_w        = mac_w_q;
   assign bus.result_valid = res_valid;
   assign bus.result_idx   = img_idx_q;
   assign bus.result_class = best_cls;
   assign bus.result_score = best_score;
endmodule

// File: tb/tb_mac_sched.sv
// Self-checking bench for mac_sched: ROM and mac1 models plus an arg-max reference per image.
module tb_mac_sched;
   import mac_pkg::*;

   localparam int NI = 40;
   localparam int NC = 10;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_bad = 0;

   logic [DATA_W-1:0] img_mem [NI];
   logic [DATA_W-1:0] w_mem   [NC];

   mac_sched_if bus ();

   mac_sched #(.NUM_IMAGES(NI), .NUM_CLASSES(NC)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Lane-wise dot product: stands in for mac1 and feeds the reference
   function automatic logic [SUM_W-1:0] dot(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
      int s = 0;
      for (int l = 0; l < LANES; l++) s += int'(a[8*l +: 8]) * int'(b[8*l +: 8]);
      return SUM_W'(s);
   endfunction

   function automatic logic [DATA_W-1:0] rep(input logic [7:0] b);
      return {LANES{b}};
   endfunction

   // Winning class is the first class reaching the maximum sum
   function automatic void ref_result(input int img, output logic [CLS_W-1:0] c, output logic [SUM_W-1:0] s);
      int best = -1;
      c = '0;
      s = '0;
      for (int k = 0; k < NC; k++) begin
         int v = int'(dot(img_mem[img], w_mem[k]));
         if (v > best) begin
            best = v;
            c = CLS_W'(k);
            s = SUM_W'(v);
         end
      end
   endfunction

   always @(posedge clk) begin
      if (bus.img_re && int'(bus.img_addr) < NI) bus.img_rdata <= img_mem[bus.img_addr];
      if (bus.w_re && int'(bus.w_addr) < NC) bus.w_rdata <= w_mem[bus.w_addr];
   end

   assign bus.mac_s = dot(bus.mac_p, bus.mac_w);

   task automatic fill_random();
      for (int i = 0; i < NI; i++) img_mem[i] = {$urandom, $urandom, $urandom, $urandom};
      for (int k = 0; k < NC; k++) w_mem[k] = {$urandom, $urandom, $urandom, $urandom};
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      bus.start = 1'b0;
      bus.result_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Returns at the negedge following the edge that samples start
   task automatic start_batch();
      @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   // cyc = number of edges after the start edge when result_valid is first seen
   task automatic wait_valid(output int cyc, output bit ok);
      cyc = 0;
      ok  = 1'b0;
      while (cyc < 200) begin
         if (bus.result_valid === 1'b1) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.start = 1'b1;
      bus.result_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if ({bus.busy, bus.done, bus.img_re, bus.w_re, bus.result_valid} !== 5'b0) begin
         n_bad++;
         $display("FAIL reset_ctrl: got %b required 00000", {bus.busy, bus.done, bus.img_re, bus.w_re, bus.result_valid});
      end
      n_cmp++;
      if ({bus.mac_p, bus.mac_w} !== '0) begin
         n_bad++;
         $display("FAIL reset_mac: got p=%h w=%h required 0", bus.mac_p, bus.mac_w);
      end
      n_cmp++;
      if ({bus.img_addr, bus.w_addr, bus.result_idx, bus.result_class, bus.result_score} !== '0) begin
         n_bad++;
         $display("FAIL reset_fields: got idx=%h cls=%h score=%h required 0", bus.result_idx, bus.result_class, bus.result_score);
      end
      $display("reset: busy=%b valid=%b", bus.busy, bus.result_valid);
      bus.start = 1'b0;
      rst = 1'b0;
   endtask

   task automatic test_winner();
      int cyc;
      bit ok;
      do_reset();
      fill_random();
      img_mem[0] = rep(8'h01);
      for (int k = 0; k < NC; k++) w_mem[k] = rep(8'h01);
      w_mem[7] = rep(8'h10);
      start_batch();
      wait_valid(cyc, ok);
      $display("winner: idx=%0d class=%0d score=%h cyc=%0d", bus.result_idx, bus.result_class, bus.result_score, cyc);
      n_cmp++;
      if (!ok || cyc != 31) begin
         n_bad++;
         $display("FAIL winner_latency: got %0d edges (ok=%0d) required 31 (valid in cycle 32)", cyc, ok);
      end
      n_cmp++;
      if (bus.result_class !== 4'd7 || bus.result_score !== 20'h00100 || bus.result_idx !== 6'd0) begin
         n_bad++;
         $display("FAIL winner_result: got idx=%0d class=%0d score=%h required 0/7/00100", bus.result_idx, bus.result_class, bus.result_score);
      end
   endtask

   task automatic test_tie();
      int cyc;
      bit ok;
      do_reset();
      fill_random();
      img_mem[0] = rep(8'h03);
      for (int k = 0; k < NC; k++) w_mem[k] = rep(8'h02);
      start_batch();
      wait_valid(cyc, ok);
      $display("tie: idx=%0d class=%0d score=%h", bus.result_idx, bus.result_class, bus.result_score);
      n_cmp++;
      if (!ok || bus.result_class !== 4'd0 || bus.result_score !== 20'h00060) begin
         n_bad++;
         $display("FAIL tie_break: got class=%0d score=%h ok=%0d required 0/00060", bus.result_class, bus.result_score, ok);
      end
   endtask

   task automatic test_max();
      int cyc;
      bit ok;
      do_reset();
      fill_random();
      img_mem[0] = rep(8'hFF);
      for (int k = 0; k < NC; k++) w_mem[k] = rep(8'h00);
      w_mem[3] = rep(8'hFF);
      start_batch();
      wait_valid(cyc, ok);
      $display("max: idx=%0d class=%0d score=%h", bus.result_idx, bus.result_class, bus.result_score);
      n_cmp++;
      if (!ok || bus.result_class !== 4'd3 || bus.result_score !== MAX_SUM) begin
         n_bad++;
         $display("FAIL max_sum: got class=%0d score=%h ok=%0d required 3/%h", bus.result_class, bus.result_score, ok, MAX_SUM);
      end
   endtask

   task automatic test_backpressure();
      int cyc;
      bit ok;
      logic [CLS_W-1:0] ec;
      logic [SUM_W-1:0] es;
      do_reset();
      fill_random();
      ref_result(0, ec, es);
      bus.result_ready = 1'b0;
      start_batch();
      wait_valid(cyc, ok);
      n_cmp++;
      if (!ok) begin
         n_bad++;
         $display("FAIL bp_timeout: result_valid not seen within 200 cycles");
      end
      for (int i = 0; i < 10; i++) begin
         n_cmp++;
         if (bus.result_valid !== 1'b1 || bus.img_re !== 1'b0 || bus.w_re !== 1'b0 ||
             bus.result_idx !== 6'd0 || bus.result_class !== ec || bus.result_score !== es) begin
            n_bad++;
            $display("FAIL bp_hold[%0d]: got v=%b ire=%b wre=%b idx=%0d cls=%0d sc=%h required 1/0/0/0/%0d/%h",
                     i, bus.result_valid, bus.img_re, bus.w_re, bus.result_idx, bus.result_class, bus.result_score, ec, es);
         end
         @(negedge clk);
      end
      $display("backpressure: idx=%0d class=%0d score=%h", bus.result_idx, bus.result_class, bus.result_score);
      bus.result_ready = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (bus.result_valid !== 1'b0 || bus.img_re !== 1'b1 || bus.img_addr !== 6'd1) begin
         n_bad++;
         $display("FAIL bp_release: got v=%b ire=%b addr=%0d required 0/1/1", bus.result_valid, bus.img_re, bus.img_addr);
      end
   endtask

   task automatic test_full_batch();
      int cyc = 0;
      int n = 0;
      int done_cnt = 0;
      int done_cyc = -1;
      logic [CLS_W-1:0] ec;
      logic [SUM_W-1:0] es;
      do_reset();
      fill_random();
      start_batch();
      while (cyc < 1290) begin
         @(negedge clk);
         cyc++;
         if (cyc == 500) bus.start = 1'b1;
         if (cyc == 501) bus.start = 1'b0;
         if (bus.result_valid === 1'b1) begin
            ref_result(n, ec, es);
            $display("batch txn %0d: idx=%0d class=%0d score=%h cyc=%0d", n, bus.result_idx, bus.result_class, bus.result_score, cyc);
            n_cmp++;
            if (bus.result_idx !== IMG_AW'(n) || bus.result_class !== ec || bus.result_score !== es) begin
               n_bad++;
               $display("FAIL batch_result[%0d]: got idx=%0d cls=%0d sc=%h required %0d/%0d/%h",
                        n, bus.result_idx, bus.result_class, bus.result_score, n, ec, es);
            end
            n_cmp++;
            if (cyc != 31 + 32 * n) begin
               n_bad++;
               $display("FAIL batch_timing[%0d]: got cycle %0d required %0d", n, cyc, 31 + 32 * n);
            end
            n++;
         end
         if (bus.done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
            n_cmp++;
            if (bus.busy !== 1'b0) begin
               n_bad++;
               $display("FAIL batch_busy_at_done: got %b required 0", bus.busy);
            end
         end
      end
      n_cmp++;
      if (n != NI || done_cnt != 1 || done_cyc != 1280) begin
         n_bad++;
         $display("FAIL batch_done: got %0d results, %0d done pulses at %0d required 40/1/1280", n, done_cnt, done_cyc);
      end
      n_cmp++;
      if (bus.busy !== 1'b0) begin
         n_bad++;
         $display("FAIL batch_idle: got busy=%b required 0", bus.busy);
      end
   endtask

   task automatic test_reset_mid();
      int cyc = 0;
      bit ok;
      logic [CLS_W-1:0] ec;
      logic [SUM_W-1:0] es;
      do_reset();
      fill_random();
      start_batch();
      // Image 5, class 4 sits in CMP right after edge 32*5 + 3 + 3*4 = 175
      while (cyc < 175) begin
         @(negedge clk);
         cyc++;
      end
      n_cmp++;
      if (bus.mac_p !== img_mem[5] || bus.mac_w !== w_mem[4]) begin
         n_bad++;
         $display("FAIL mid_operands: got p=%h w=%h required %h %h", bus.mac_p, bus.mac_w, img_mem[5], w_mem[4]);
      end
      rst = 1'b1;
      @(negedge clk);
      n_cmp++;
      if ({bus.busy, bus.done, bus.img_re, bus.w_re, bus.result_valid} !== 5'b0 || {bus.mac_p, bus.mac_w} !== '0 ||
          {bus.result_idx, bus.result_class, bus.result_score} !== '0) begin
         n_bad++;
         $display("FAIL mid_reset: got busy=%b v=%b p=%h idx=%0d cls=%0d sc=%h required all 0",
                  bus.busy, bus.result_valid, bus.mac_p, bus.result_idx, bus.result_class, bus.result_score);
      end
      rst = 1'b0;
      ref_result(0, ec, es);
      start_batch();
      wait_valid(cyc, ok);
      $display("restart: idx=%0d class=%0d score=%h cyc=%0d", bus.result_idx, bus.result_class, bus.result_score, cyc);
      n_cmp++;
      if (!ok || cyc != 31 || bus.result_idx !== 6'd0 || bus.result_class !== ec || bus.result_score !== es) begin
         n_bad++;
         $display("FAIL mid_restart: got idx=%0d cls=%0d sc=%h cyc=%0d required 0/%0d/%h/31",
                  bus.result_idx, bus.result_class, bus.result_score, cyc, ec, es);
      end
   endtask

   initial begin
      bus.start = 1'b0;
      bus.result_ready = 1'b1;
      test_reset();
      test_winner();
      test_tie();
      test_max();
      test_backpressure();
      test_full_batch();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
